// File: rtl/fib_arbiter.sv
// fib_arbiter: shares one Fibonacci core among NUM_REQ requesters.
// Requests are granted round-robin, and the core go/done handshake is sequenced.
// The core's result and overflow are returned to the requester that was granted.
// The optional core-response watchdog is built when FIB_ARBITER_TIMEOUT_EN is defined.
module fib_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [OUTPUT_WIDTH-1:0]        rsp_result,
  output logic                           rsp_overflow,
  output logic                           rsp_error,
  output logic                           busy,
  output logic                           core_go,
  output logic [INPUT_WIDTH-1:0]         core_n,
  input  logic [OUTPUT_WIDTH-1:0]        core_result,
  input  logic                           core_overflow,
  input  logic                           core_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t                 state_r;
  logic [PTR_W-1:0]       ptr_r;
  logic [PTR_W-1:0]       owner_r;
  logic [PTR_W-1:0]       pick_s;
  logic [INPUT_WIDTH-1:0] pick_n_s;
  logic                   any_req_s;
  logic                   timeout_s;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fib_arbiter: unsupported parameter set");
  end

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) next_ptr = '0;
    else                          next_ptr = idx + PTR_W'(1);
  endfunction

  // First set request bit searching upward from start, wrapping at NUM_REQ
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                               input logic [PTR_W-1:0]   start);
    int   idx;
    logic found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      else                idx = idx;
      if (!found && vec[PTR_W'(idx)]) begin
        found   = 1'b1;
        rr_pick = PTR_W'(idx);
      end else begin
        found   = found;
      end
    end
  endfunction

  // Winner of round-robin arbitration and its operand slice
  always_comb begin
    any_req_s = |req_valid;
    pick_s    = rr_pick(req_valid, ptr_r);
    pick_n_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_s == PTR_W'(k)) pick_n_s = req_n[k*INPUT_WIDTH +: INPUT_WIDTH];
      else                     pick_n_s = pick_n_s;
    end
  end

`ifdef FIB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_r;
  logic             wd_limit_s;

  // Watchdog expiry; a done arriving in the expiry cycle still wins
  always_comb begin
    wd_limit_s = (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    case (state_r)
      WAIT_CLR:  timeout_s = wd_limit_s;
      WAIT_DONE: timeout_s = wd_limit_s && !core_done;
      default:   timeout_s = 1'b0;
    endcase
  end

  // Count core-wait cycles for the current job and flag an expired response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r  <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_error <= timeout_s;
      if (state_r == ISSUE) begin
        wd_cnt_r <= '0;
      end else if ((state_r == WAIT_CLR || state_r == WAIT_DONE) && !timeout_s) begin
        wd_cnt_r <= wd_cnt_r + CNT_W'(1);
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign rsp_error = 1'b0;
`endif

  // Arbitrate, sequence the core handshake and register every response output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= '0;
      owner_r      <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      busy         <= 1'b0;
      core_go      <= 1'b0;
      core_n       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid <= '0;
          if (any_req_s) begin
            req_ready <= to_onehot(pick_s);
            owner_r   <= pick_s;
            core_n    <= pick_n_s;
            core_go   <= 1'b1;
            busy      <= 1'b1;
            ptr_r     <= next_ptr(pick_s);
            state_r   <= ISSUE;
          end else begin
            req_ready <= '0;
            core_go   <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        ISSUE: begin
          req_ready <= '0;
          core_go   <= 1'b0;
          state_r   <= WAIT_CLR;
        end
        WAIT_CLR: begin
          // A done still high here belongs to the previous job
          if (timeout_s) begin
            rsp_valid    <= to_onehot(owner_r);
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            state_r      <= RESPOND;
          end else if (!core_done) begin
            state_r <= WAIT_DONE;
          end else begin
            state_r <= WAIT_CLR;
          end
        end
        WAIT_DONE: begin
          if (core_done) begin
            rsp_valid    <= to_onehot(owner_r);
            rsp_result   <= core_result;
            rsp_overflow <= core_overflow;
            state_r      <= RESPOND;
          end else if (timeout_s) begin
            rsp_valid    <= to_onehot(owner_r);
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            state_r      <= RESPOND;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        RESPOND: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          req_ready <= '0;
          rsp_valid <= '0;
          core_go   <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed self-checking bench for fib_arbiter with a behavioural Fibonacci core.
module tb_fib_arbiter;

  localparam int NR   = 4;
  localparam int IW   = 6;
  localparam int OW   = 32;
  localparam int TO   = 16;
  localparam int LAT  = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*IW-1:0] req_n;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] rsp_valid;
  logic [OW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_error;
  logic          busy;
  logic          core_go;
  logic [IW-1:0] core_n;
  logic [OW-1:0] core_result;
  logic          core_overflow;
  logic          core_done;

  int n_checks;
  int n_fail;

  // Core model controls
  int   stale_hold;
  logic stuck;
  int   hold_cnt;
  int   lat_cnt;
  logic pending;
  logic [IW-1:0] n_q;

  fib_arbiter #(
    .NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .busy(busy),
    .core_go(core_go), .core_n(core_n),
    .core_result(core_result), .core_overflow(core_overflow), .core_done(core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] core_fib(input logic [IW-1:0] n);
    longint unsigned a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b; a = b; b = t;
    end
    return {(a > 64'h0000_0000_FFFF_FFFF), a[31:0]};
  endfunction

  // Behavioural core: clears done after go (optionally late), finishes after LAT cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_done <= 1'b0; core_result <= '0; core_overflow <= 1'b0;
      pending <= 1'b0; hold_cnt <= 0; lat_cnt <= 0; n_q <= '0;
    end else if (core_go) begin
      pending  <= 1'b1;
      hold_cnt <= stale_hold;
      lat_cnt  <= LAT;
      n_q      <= core_n;
      if (stale_hold == 0) core_done <= 1'b0;
    end else if (pending && !stuck) begin
      if (hold_cnt > 0) begin
        if (hold_cnt == 1) core_done <= 1'b0;
        hold_cnt <= hold_cnt - 1;
      end else if (lat_cnt > 1) begin
        lat_cnt <= lat_cnt - 1;
      end else begin
        core_done <= 1'b1;
        {core_overflow, core_result} <= core_fib(n_q);
        pending <= 1'b0;
      end
    end
  end

  task automatic wait_ready(output logic [NR-1:0] seen);
    seen = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = req_ready;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output logic [NR-1:0] v, output logic [OW-1:0] res,
                          output logic ovf, output logic err, output int cycles,
                          output logic saw_low);
    v = '0; res = '0; ovf = 1'b0; err = 1'b0; cycles = 0; saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles = cycles + 1;
      if (!core_done) saw_low = 1'b1;
      if (rsp_valid != '0) begin
        v = rsp_valid; res = rsp_result; ovf = rsp_overflow; err = rsp_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_overflow, rsp_error, busy, core_go} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {req_ready, rsp_valid, rsp_overflow, rsp_error, busy, core_go});
    end
    n_checks++;
    if (rsp_result !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got %0d expected 0", rsp_result);
    end
    n_checks++;
    if (core_n !== 6'd0) begin
      n_fail++; $display("FAIL reset_core_n: got %0d expected 0", core_n);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NR-1:0] seen, v;
    logic [OW-1:0] res;
    logic ovf, err, sl;
    int cyc;
    req_n = '0; req_n[5:0] = 6'd10; req_valid = 4'b0001;
    wait_ready(seen);
    n_checks++;
    if (seen !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b expected 0001", seen);
    end
    n_checks++;
    if ({core_go, core_n, busy} !== {1'b1, 6'd10, 1'b1}) begin
      n_fail++; $display("FAIL single_issue: go=%b n=%0d busy=%b expected go=1 n=10 busy=1",
                         core_go, core_n, busy);
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if ({core_go, req_ready} !== 5'b0) begin
      n_fail++; $display("FAIL single_go_pulse: go=%b ready=%b expected 0/0000", core_go, req_ready);
    end
    wait_rsp(v, res, ovf, err, cyc, sl);
    n_checks++;
    if ({v, res, ovf, err} !== {4'b0001, 32'd55, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_rsp: v=%b res=%0d ovf=%b err=%b expected 0001/55/0/0",
                         v, res, ovf, err);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, busy, rsp_result} !== {4'b0000, 1'b0, 32'd55}) begin
      n_fail++; $display("FAIL single_after: v=%b busy=%b res=%0d expected 0000/0/55",
                         rsp_valid, busy, rsp_result);
    end
  endtask

  task automatic test_edge_operands();
    logic [IW-1:0] ns [5]  = '{6'd0, 6'd1, 6'd2, 6'd47, 6'd48};
    logic [OW-1:0] exp [5] = '{32'd0, 32'd1, 32'd1, 32'd2971215073, 32'd512559680};
    logic          eo [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [NR-1:0] seen, v;
    logic [OW-1:0] res;
    logic ovf, err, sl;
    int cyc;
    for (int j = 0; j < 5; j++) begin
      req_n = '0; req_n[23:18] = ns[j]; req_valid = 4'b1000;
      wait_ready(seen);
      req_valid = '0;
      n_checks++;
      if (seen !== 4'b1000) begin
        n_fail++; $display("FAIL edge_ready n=%0d: got %b expected 1000", ns[j], seen);
      end
      wait_rsp(v, res, ovf, err, cyc, sl);
      n_checks++;
      if ({v, res} !== {4'b1000, exp[j]}) begin
        n_fail++; $display("FAIL edge_result n=%0d: v=%b res=%0d expected 1000/%0d",
                           ns[j], v, res, exp[j]);
      end
      n_checks++;
      if ({ovf, err} !== {eo[j], 1'b0}) begin
        n_fail++; $display("FAIL edge_flags n=%0d: ovf=%b err=%b expected %b/0", ns[j], ovf, err, eo[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] gexp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [OW-1:0] rexp [5] = '{32'd5, 32'd8, 32'd13, 32'd21, 32'd5};
    logic [NR-1:0] seen, v;
    logic [OW-1:0] res;
    logic ovf, err, sl;
    int cyc;
    req_n = {6'd8, 6'd7, 6'd6, 6'd5};
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ready(seen);
      n_checks++;
      if (seen !== gexp[j]) begin
        n_fail++; $display("FAIL rr_grant job%0d: got %b expected %b", j, seen, gexp[j]);
      end
      wait_rsp(v, res, ovf, err, cyc, sl);
      if (j == 4) req_valid = '0;
      n_checks++;
      if ({v, res} !== {gexp[j], rexp[j]}) begin
        n_fail++; $display("FAIL rr_rsp job%0d: v=%b res=%0d expected %b/%0d",
                           j, v, res, gexp[j], rexp[j]);
      end
    end
  endtask

  task automatic test_stale_done();
    logic [NR-1:0] seen, v;
    logic [OW-1:0] res;
    logic ovf, err, sl;
    int cyc;
    @(negedge clk); @(negedge clk);
    stale_hold = 3;
    req_n = '0; req_n[11:6] = 6'd9; req_valid = 4'b0010;
    wait_ready(seen);
    req_valid = '0;
    n_checks++;
    if (seen !== 4'b0010) begin
      n_fail++; $display("FAIL stale_ready: got %b expected 0010", seen);
    end
    wait_rsp(v, res, ovf, err, cyc, sl);
    n_checks++;
    if ({v, res, sl} !== {4'b0010, 32'd34, 1'b1}) begin
      n_fail++; $display("FAIL stale_rsp: v=%b res=%0d done_fell=%b expected 0010/34/1", v, res, sl);
    end
    n_checks++;
    if (cyc !== 9) begin
      n_fail++; $display("FAIL stale_latency: got %0d cycles expected 9", cyc);
    end
    stale_hold = 0;
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] seen, v;
    logic [OW-1:0] res;
    logic ovf, err, sl;
    int cyc;
    int stray;
    req_n = '0; req_n[17:12] = 6'd20; req_valid = 4'b0100;
    wait_ready(seen);
    req_valid = '0;
    n_checks++;
    if (seen !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_ready: got %b expected 0100", seen);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_overflow, rsp_error, busy, core_go, core_n, rsp_result} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: busy=%b go=%b n=%0d res=%0d v=%b expected all 0",
                         busy, core_go, core_n, rsp_result, rsp_valid);
    end
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", stray);
    end
    req_n = {6'd4, 6'd3, 6'd2, 6'd12}; req_valid = 4'b1111;
    wait_ready(seen);
    req_valid = '0;
    n_checks++;
    if (seen !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_ptr: got %b expected 0001", seen);
    end
    wait_rsp(v, res, ovf, err, cyc, sl);
    n_checks++;
    if ({v, res} !== {4'b0001, 32'd144}) begin
      n_fail++; $display("FAIL rstmid_rsp: v=%b res=%0d expected 0001/144", v, res);
    end
  endtask

`ifdef FIB_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    logic [NR-1:0] seen, v;
    logic [OW-1:0] res;
    logic ovf, err, sl;
    int cyc;
    stuck = 1'b1;
    req_n = '0; req_n[11:6] = 6'd10; req_valid = 4'b0010;
    wait_ready(seen);
    req_valid = '0;
    n_checks++;
    if (seen !== 4'b0010) begin
      n_fail++; $display("FAIL timeout_ready: got %b expected 0010", seen);
    end
    wait_rsp(v, res, ovf, err, cyc, sl);
    n_checks++;
    if ({v, res, ovf, err} !== {4'b0010, 32'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_rsp: v=%b res=%0d ovf=%b err=%b expected 0010/0/0/1",
                         v, res, ovf, err);
    end
    n_checks++;
    if (cyc !== 17) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles expected 17", cyc);
    end
    stuck = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "tb_fib_arbiter stopped by time limit");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    stale_hold = 0; stuck = 1'b0;
    rst = 1'b1; req_valid = '0; req_n = '0;
    test_reset();
    test_single();
    test_edge_operands();
    test_round_robin();
    test_stale_done();
    test_reset_mid();
`ifdef FIB_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
